regfile_wb_queue: RTL and testbench

//   Writeback queue that owns the register file's single write port.
//   - Accepts results (rd, data) from the execute/load side over a valid/ready handshake.
//   - Buffers them in order and drains at most one per cycle onto RegWrite/rd/write_data.
//   - Reports per-register pending status for the two decode read ports (rs1/rs2) so

---
 rtl/regfile_wb_queue.sv | 137 +++++++++++++
 tb/tb_regfile_wb_queue.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// Writeback queue owning the single regfile write port, with per-register pending status.
// Optional bypass outputs are enabled by defining WB_BYPASS_EN.
module regfile_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RAW   = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RAW-1:0]           in_rd,
    input  logic [XLEN-1:0]          in_data,
    output logic                     RegWrite,
    output logic [RAW-1:0]           rd,
    output logic [XLEN-1:0]          write_data,
    input  logic [RAW-1:0]           rs1,
    input  logic [RAW-1:0]           rs2,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic                     rs1_fwd_valid,
    output logic [XLEN-1:0]          rs1_fwd_data,
    output logic                     rs2_fwd_valid,
    output logic [XLEN-1:0]          rs2_fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [RAW-1:0]  rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic            accept, store, drain;

    assign in_ready = (count_q != CW'(DEPTH));
    assign accept   = in_valid && in_ready;
    // x0 writes complete the handshake but are never queued.
    assign store    = accept && (in_rd != '0);
    // An entry accepted this edge is not yet in count_q, so no flow-through.
    assign drain    = (count_q != '0);
    assign count    = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (store) begin
            tail_d = tail_q + PW'(1);
        end
        if (drain) begin
            head_d = head_q + PW'(1);
        end
        if (store && !drain) begin
            count_d = count_q + CW'(1);
        end else if (!store && drain) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            RegWrite   <= 1'b0;
            rd         <= '0;
            write_data <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            RegWrite <= drain;
            if (drain) begin
                rd         <= rd_mem[head_q];
                write_data <= data_mem[head_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            rd_mem[tail_q]   <= in_rd;
            data_mem[tail_q] <= in_data;
        end
    end

    logic rs1_hit, rs2_hit;
`ifdef WB_BYPASS_EN
    logic [XLEN-1:0] rs1_sel, rs2_sel;
`endif

    // Scan oldest to youngest so the last match is the value the regfile ends up holding.
    always_comb begin
        rs1_hit = RegWrite && (rd == rs1);
        rs2_hit = RegWrite && (rd == rs2);
`ifdef WB_BYPASS_EN
        rs1_sel = rs1_hit ? write_data : '0;
        rs2_sel = rs2_hit ? write_data : '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] idx;
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (rd_mem[idx] == rs1) begin
                    rs1_hit = 1'b1;
`ifdef WB_BYPASS_EN
                    rs1_sel = data_mem[idx];
`endif
                end
                if (rd_mem[idx] == rs2) begin
                    rs2_hit = 1'b1;
`ifdef WB_BYPASS_EN
                    rs2_sel = data_mem[idx];
`endif
                end
            end
        end
    end

    assign rs1_busy = rs1_hit && (rs1 != '0);
    assign rs2_busy = rs2_hit && (rs2 != '0);

`ifdef WB_BYPASS_EN
    assign rs1_fwd_valid = rs1_busy;
    assign rs2_fwd_valid = rs2_busy;
    assign rs1_fwd_data  = rs1_busy ? rs1_sel : '0;
    assign rs2_fwd_data  = rs2_busy ? rs2_sel : '0;
`else
    assign rs1_fwd_valid = 1'b0;
    assign rs2_fwd_valid = 1'b0;
    assign rs1_fwd_data  = '0;
    assign rs2_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue; bypass checks follow WB_BYPASS_EN.
module tb_regfile_wb_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_data = '0;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid;
    logic [31:0] rs1_fwd_data, rs2_fwd_data;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_queue #(.DEPTH(4), .XLEN(32), .RAW(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data), .RegWrite(RegWrite), .rd(rd),
        .write_data(write_data), .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy), .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        n_cmp++; if ({RegWrite, rd, write_data, count} !== 41'd0) begin
            n_err++; $display("FAIL reset_in_reset got %h want 0", {RegWrite, rd, write_data, count});
        end
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1; in_rd = 5'd3; in_data = 32'h33;
        tick();
        in_rd = 5'd4; in_data = 32'h44;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (RegWrite !== 1'b1 || count !== 3'd1) begin
            n_err++; $display("FAIL reset_preburst got rw=%b cnt=%0d want rw=1 cnt=1", RegWrite, count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({RegWrite, rd, write_data, count} !== 41'd0) begin
            n_err++; $display("FAIL reset_async got %h want 0", {RegWrite, rd, write_data, count});
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (RegWrite !== 1'b0 || count !== 3'd0) begin
                n_err++; $display("FAIL reset_no_write got rw=%b cnt=%0d want 0/0", RegWrite, count);
            end
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_rd = 5'd5; in_data = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (RegWrite !== 1'b0 || count !== 3'd1) begin
            n_err++; $display("FAIL single_k got rw=%b cnt=%0d want 0/1", RegWrite, count);
        end
        tick();
        n_cmp++; if (RegWrite !== 1'b1 || rd !== 5'd5 || write_data !== 32'hDEADBEEF || count !== 3'd0) begin
            n_err++; $display("FAIL single_k1 got rw=%b rd=%0d wd=%h cnt=%0d want 1/5/deadbeef/0",
                              RegWrite, rd, write_data, count);
        end
        tick();
        n_cmp++; if (RegWrite !== 1'b0 || rd !== 5'd5 || write_data !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL single_k2 got rw=%b rd=%0d wd=%h want 0/5/deadbeef hold",
                              RegWrite, rd, write_data);
        end
    endtask

    // Six writes so both pointers wrap past DEPTH-1.
    task automatic test_ordering();
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; in_rd = 5'(i); in_data = 32'h100 + 32'(i);
            n_cmp++; if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL order_ready[%0d] got %b want 1", i, in_ready);
            end
            tick();
            if (i >= 2) begin
                n_cmp++; if (RegWrite !== 1'b1 || rd !== 5'(i - 1) || write_data !== 32'h100 + 32'(i - 1)
                             || count !== 3'd1) begin
                    n_err++; $display("FAIL order_out[%0d] got rw=%b rd=%0d wd=%h cnt=%0d want 1/%0d/%h/1",
                                      i, RegWrite, rd, write_data, count, i - 1, 32'h100 + 32'(i - 1));
                end
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (RegWrite !== 1'b1 || rd !== 5'd6 || write_data !== 32'h106 || count !== 3'd0) begin
            n_err++; $display("FAIL order_last got rw=%b rd=%0d wd=%h cnt=%0d want 1/6/106/0",
                              RegWrite, rd, write_data, count);
        end
        tick();
        n_cmp++; if (RegWrite !== 1'b0) begin
            n_err++; $display("FAIL order_idle got rw=%b want 0", RegWrite);
        end
    endtask

    task automatic test_x0_drop();
        in_valid = 1'b1; in_rd = 5'd0; in_data = 32'h1234;
        n_cmp++; if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL x0_ready got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (count !== 3'd0 || RegWrite !== 1'b0) begin
            n_err++; $display("FAIL x0_count got cnt=%0d rw=%b want 0/0", count, RegWrite);
        end
        tick();
        n_cmp++; if (RegWrite !== 1'b0 || write_data === 32'h1234) begin
            n_err++; $display("FAIL x0_nowrite got rw=%b wd=%h want rw=0", RegWrite, write_data);
        end
    endtask

    task automatic test_busy();
        rs1 = 5'd7; rs2 = 5'd0;
        in_valid = 1'b1; in_rd = 5'd7; in_data = 32'd1;
        #1;
        n_cmp++; if (rs1_busy !== 1'b0) begin
            n_err++; $display("FAIL busy_accepting got %b want 0", rs1_busy);
        end
        tick();
        in_data = 32'd2;
        tick();
        in_valid = 1'b0;
        // Output stage holds data 1, queue holds data 2.
        n_cmp++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
            n_err++; $display("FAIL busy_both got rs1=%b rs2=%b want 1/0", rs1_busy, rs2_busy);
        end
`ifdef WB_BYPASS_EN
        n_cmp++; if (rs1_fwd_valid !== 1'b1 || rs1_fwd_data !== 32'd2 || rs2_fwd_valid !== 1'b0) begin
            n_err++; $display("FAIL fwd_youngest got v=%b d=%0d v2=%b want 1/2/0",
                              rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid);
        end
`else
        n_cmp++; if (rs1_fwd_valid !== 1'b0 || rs1_fwd_data !== 32'd0) begin
            n_err++; $display("FAIL fwd_off got v=%b d=%h want 0/0", rs1_fwd_valid, rs1_fwd_data);
        end
`endif
        tick();
        n_cmp++; if (rs1_busy !== 1'b1 || RegWrite !== 1'b1 || write_data !== 32'd2) begin
            n_err++; $display("FAIL busy_last got busy=%b rw=%b wd=%0d want 1/1/2",
                              rs1_busy, RegWrite, write_data);
        end
        tick();
        n_cmp++; if (rs1_busy !== 1'b0 || RegWrite !== 1'b0) begin
            n_err++; $display("FAIL busy_clear got busy=%b rw=%b want 0/0", rs1_busy, RegWrite);
        end
        rs1 = 5'd0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_ordering();
        test_x0_drop();
        test_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
